// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared note codes, divider defaults, FSM states and FIFO entry width
package sound_pkg;

   localparam logic [1:0] NOTE_DO  = 2'd0;
   localparam logic [1:0] NOTE_RE  = 2'd1;
   localparam logic [1:0] NOTE_MI  = 2'd2;
   localparam logic [1:0] NOTE_SOL = 2'd3;

   localparam logic [31:0] DEF_NOTE_LEN = 32'd5_000_000;
   localparam logic [31:0] DEF_GAP_LEN  = 32'd1_000_000;
   localparam logic [31:0] DEF_DIV_DO   = 32'hBAA;
   localparam logic [31:0] DEF_DIV_RE   = 32'hA64;
   localparam logic [31:0] DEF_DIV_MI   = 32'h941;
   localparam logic [31:0] DEF_DIV_SOL  = 32'h7C9;

   // FIFO entry layout: {double_len, code[1:0]}
   localparam int FIFO_W = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_GAP
   } state_t;

endpackage

// File: rtl/sound_event_fifo.sv
// rtl/sound_event_fifo.sv - 4-deep event queue; a push while full is accepted only alongside a pop
module sound_event_fifo
   import sound_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [FIFO_W-1:0] wdata,
   output logic [FIFO_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   logic [FIFO_W-1:0] mem_q [4];
   logic [FIFO_W-1:0] mem_d [4];
   logic [1:0]        wr_ptr_q, wr_ptr_d;
   logic [1:0]        rd_ptr_q, rd_ptr_d;
   logic [2:0]        count_q, count_d;
   logic              do_push, do_pop;

   assign empty   = (count_q == 3'd0);
   assign full    = (count_q == 3'd4);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - queues game-event edges and plays each as a fixed-length note then a silent gap
module sound_sequencer
   import sound_pkg::*;
#(
   parameter logic [31:0] NOTE_LEN = DEF_NOTE_LEN,
   parameter logic [31:0] GAP_LEN  = DEF_GAP_LEN,
   parameter logic [31:0] DIV_DO   = DEF_DIV_DO,
   parameter logic [31:0] DIV_RE   = DEF_DIV_RE,
   parameter logic [31:0] DIV_MI   = DEF_DIV_MI,
   parameter logic [31:0] DIV_SOL  = DEF_DIV_SOL
) (
   input  logic       clk,
   input  logic       reset_button,
   input  logic       hit_paddle,
   input  logic       hit_brick,
   input  logic       life_lost,
   output logic [4:0] rom_addr,
   output logic       tone_en,
   output logic [1:0] note,
   output logic       busy,
   output logic       overflow
);

   logic              paddle_prev_q, paddle_prev_d;
   logic              brick_prev_q, brick_prev_d;
   logic              life_prev_q, life_prev_d;
   logic              overflow_q, overflow_d;
   logic              ev_valid;
   logic [FIFO_W-1:0] ev_data;

   logic              fifo_pop, fifo_full, fifo_empty;
   logic [FIFO_W-1:0] fifo_rdata;

   state_t            state_q, state_d;
   logic [1:0]        note_q, note_d;
   logic              dbl_q, dbl_d;
   logic [4:0]        rom_addr_q, rom_addr_d;
   logic [32:0]       step_q, step_d;
   logic [32:0]       dur_q, dur_d;
   logic [31:0]       div;
   logic [32:0]       step_last, dur_last, gap_last;

   // Edge detect with fixed priority; only the winning edge is ever offered to the FIFO.
   always_comb begin
      paddle_prev_d = hit_paddle;
      brick_prev_d  = hit_brick;
      life_prev_d   = life_lost;
      ev_valid      = 1'b1;
      if (life_lost & ~life_prev_q) begin
         ev_data = {1'b1, NOTE_SOL};
      end else if (hit_brick & ~brick_prev_q) begin
         ev_data = {1'b0, NOTE_RE};
      end else if (hit_paddle & ~paddle_prev_q) begin
         ev_data = {1'b0, NOTE_DO};
      end else begin
         ev_valid = 1'b0;
         ev_data  = '0;
      end
      overflow_d = overflow_q | (ev_valid & fifo_full & ~fifo_pop);
   end

   sound_event_fifo u_fifo (
      .clk   (clk),
      .rst_n (reset_button),
      .push  (ev_valid),
      .pop   (fifo_pop),
      .wdata (ev_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      case (note_q)
         NOTE_DO: div = DIV_DO;
         NOTE_RE: div = DIV_RE;
         NOTE_MI: div = DIV_MI;
         default: div = DIV_SOL;
      endcase
      step_last = {div, 1'b0} - 33'd1;
      dur_last  = dbl_q ? ({NOTE_LEN, 1'b0} - 33'd1) : ({1'b0, NOTE_LEN} - 33'd1);
      gap_last  = {1'b0, GAP_LEN} - 33'd1;
   end

   // dur counter is reused to time the gap; it restarts from zero on each state change.
   always_comb begin
      state_d    = state_q;
      note_d     = note_q;
      dbl_d      = dbl_q;
      rom_addr_d = rom_addr_q;
      step_d     = step_q;
      dur_d      = dur_q;
      fifo_pop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_d    = S_PLAY;
               note_d     = fifo_rdata[1:0];
               dbl_d      = fifo_rdata[2];
               rom_addr_d = 5'd0;
               step_d     = 33'd0;
               dur_d      = 33'd0;
            end
         end
         S_PLAY: begin
            if (step_q == step_last) begin
               step_d     = 33'd0;
               rom_addr_d = rom_addr_q + 5'd1;
            end else begin
               step_d = step_q + 33'd1;
            end
            if (dur_q == dur_last) begin
               state_d    = S_GAP;
               dur_d      = 33'd0;
               rom_addr_d = 5'd0;
            end else begin
               dur_d = dur_q + 33'd1;
            end
         end
         S_GAP: begin
            if (dur_q == gap_last) begin
               state_d = S_IDLE;
               dur_d   = 33'd0;
            end else begin
               dur_d = dur_q + 33'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_button) begin
      if (!reset_button) begin
         paddle_prev_q <= 1'b0;
         brick_prev_q  <= 1'b0;
         life_prev_q   <= 1'b0;
         overflow_q    <= 1'b0;
         state_q       <= S_IDLE;
         note_q        <= NOTE_DO;
         dbl_q         <= 1'b0;
         rom_addr_q    <= 5'd0;
         step_q        <= 33'd0;
         dur_q         <= 33'd0;
      end else begin
         paddle_prev_q <= paddle_prev_d;
         brick_prev_q  <= brick_prev_d;
         life_prev_q   <= life_prev_d;
         overflow_q    <= overflow_d;
         state_q       <= state_d;
         note_q        <= note_d;
         dbl_q         <= dbl_d;
         rom_addr_q    <= rom_addr_d;
         step_q        <= step_d;
         dur_q         <= dur_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign tone_en  = (state_q == S_PLAY);
   assign note     = note_q;
   assign busy     = (state_q != S_IDLE) | ~fifo_empty;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - scoreboard bench: expected notes queued at stimulus, checked when each note ends
module tb_sound_sequencer;

   localparam int T_GAP = 20;

   logic       clk = 1'b0;
   logic       reset_button;
   logic       hit_paddle, hit_brick, life_lost;
   logic [4:0] rom_addr;
   logic       tone_en;
   logic [1:0] note;
   logic       busy, overflow;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int next_free = 0;
   int st, at;

   typedef struct {
      int code;
      int len;
      int addr;
      int per;
      int start;
   } exp_t;
   exp_t sb[$];

   sound_sequencer #(
      .NOTE_LEN (32'd100),
      .GAP_LEN  (32'd20),
      .DIV_DO   (32'd4),
      .DIV_RE   (32'd5),
      .DIV_MI   (32'd6),
      .DIV_SOL  (32'd3)
   ) dut (
      .clk          (clk),
      .reset_button (reset_button),
      .hit_paddle   (hit_paddle),
      .hit_brick    (hit_brick),
      .life_lost    (life_lost),
      .rom_addr     (rom_addr),
      .tone_en      (tone_en),
      .note         (note),
      .busy         (busy),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Called at the negedge where the request input is raised; the edge is sampled at the next posedge.
   task automatic exp_note(input int code, input int len, input int addr, input int per);
      exp_t e;
      e.code  = code;
      e.len   = len;
      e.addr  = addr;
      e.per   = per;
      e.start = (cyc + 2 > next_free) ? cyc + 2 : next_free;
      next_free = e.start + len + T_GAP + 1;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name, input int bound, output int when);
      when = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!busy) begin
            when = cyc;
            break;
         end
      end
      if (when < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, bound);
      end
   endtask

   // Monitor: tracks each tone_en high window and scores it against the queue head.
   int   m_start, m_len, m_last, m_since, m_per, m_bad, m_note;
   int   gap_bad = 0;
   logic in_note = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!tone_en && rom_addr != 5'd0) gap_bad++;
         if (tone_en) begin
            if (!in_note) begin
               in_note = 1'b1;
               m_start = cyc;
               m_len   = 1;
               m_last  = int'(rom_addr);
               m_since = 0;
               m_per   = 0;
               m_bad   = (rom_addr != 5'd0) ? 1 : 0;
               m_note  = int'(note);
            end else begin
               m_len++;
               m_since++;
               if (int'(rom_addr) != m_last) begin
                  if (int'(rom_addr) != (m_last + 1) % 32) m_bad++;
                  if (m_per == 0) m_per = m_since;
                  else if (m_since != m_per) m_bad++;
                  m_since = 0;
                  m_last  = int'(rom_addr);
               end
            end
         end else if (in_note) begin
            exp_t e;
            in_note = 1'b0;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_note: got note %0d at cycle %0d, expected none", m_note, m_start);
            end else begin
               e = sb.pop_front();
               check("note_code", m_note, e.code);
               check("note_len", m_len, e.len);
               check("note_start", m_start, e.start);
               check("note_final_addr", m_last, e.addr);
               check("note_step_period", m_per, e.per);
               check("note_step_errors", m_bad, 0);
            end
         end
      end
   end

   initial begin
      reset_button = 1'b0;
      hit_paddle   = 1'b0;
      hit_brick    = 1'b0;
      life_lost    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rom_addr", int'(rom_addr), 0);
      check("reset_tone_en", int'(tone_en), 0);
      check("reset_note", int'(note), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_overflow", int'(overflow), 0);
      reset_button = 1'b1;
      repeat (8) @(negedge clk);

      // Single paddle pulse
      hit_paddle = 1'b1;
      st = cyc + 2;
      exp_note(0, 100, 12, 8);
      @(negedge clk) hit_paddle = 1'b0;
      wait_idle("paddle_idle", 400, at);
      check("paddle_idle_cycle", at, st + 120);

      // Life lost: double-length SOL
      @(negedge clk) life_lost = 1'b1;
      exp_note(3, 200, 1, 6);
      @(negedge clk) life_lost = 1'b0;
      wait_idle("life_idle", 400, at);

      // Brick and paddle together: only RE
      @(negedge clk);
      hit_brick  = 1'b1;
      hit_paddle = 1'b1;
      exp_note(1, 100, 9, 10);
      @(negedge clk);
      hit_brick  = 1'b0;
      hit_paddle = 1'b0;
      wait_idle("pair_idle", 400, at);
      check("pair_overflow", int'(overflow), 0);

      // Six paddle edges two cycles apart
      for (int i = 0; i < 6; i++) begin
         hit_paddle = 1'b1;
         if (i < 5) exp_note(0, 100, 12, 8);
         @(negedge clk) hit_paddle = 1'b0;
         if (i == 4) check("overflow_at_fill", int'(overflow), 0);
         if (i == 5) check("overflow_at_drop", int'(overflow), 1);
         @(negedge clk);
      end
      wait_idle("burst_idle", 800, at);
      check("overflow_sticky", int'(overflow), 1);

      // Reset during the 50th cycle of PLAY with two events queued
      @(negedge clk) hit_paddle = 1'b1;
      st = cyc + 2;
      exp_note(0, 49, 6, 8);
      @(negedge clk) hit_paddle = 1'b0;
      @(negedge clk) hit_brick = 1'b1;
      @(negedge clk) hit_brick = 1'b0;
      @(negedge clk) life_lost = 1'b1;
      @(negedge clk) life_lost = 1'b0;
      while (cyc < st + 48) @(negedge clk);
      check("busy_before_reset", int'(busy), 1);
      @(posedge clk);
      #1 reset_button = 1'b0;
      #1;
      check("async_tone_en", int'(tone_en), 0);
      check("async_rom_addr", int'(rom_addr), 0);
      check("async_busy", int'(busy), 0);
      check("async_overflow", int'(overflow), 0);
      repeat (3) @(negedge clk);
      reset_button = 1'b1;
      next_free = 0;
      repeat (300) @(negedge clk);
      check("queue_cleared_busy", int'(busy), 0);

      // Paddle held high for 500 cycles
      hit_paddle = 1'b1;
      exp_note(0, 100, 12, 8);
      repeat (500) @(negedge clk);
      hit_paddle = 1'b0;
      wait_idle("held_idle", 300, at);
      repeat (50) @(negedge clk);

      check("scoreboard_drained", sb.size(), 0);
      check("addr_nonzero_while_silent", gap_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Collision-sound sequencer between the ball logic and the sine-wave tone ROM. It edge-detects game events (paddle hit, brick hit, life lost) and queues them in a small FIFO. It plays each queued event as a fixed-length note, separated by a silent gap, by stepping the tone ROM address at the note's pitch rate. Its outputs drive the ROM address and a mute/enable gate ahead of the 4-bit `tono` DAC output.

## Interface
- `NOTE_LEN`, 32'd5_000_000: note duration in clk cycles (100 ms at 50 MHz).
- `GAP_LEN`, 32'd1_000_000: silent gap after each note, in cycles.
- `DIV_DO`, 32'hBAA: half-period divider for note DO.
- `DIV_RE`, 32'hA64: half-period divider for note RE.
- `DIV_MI`, 32'h941: half-period divider for note MI.
- `DIV_SOL`, 32'h7C9: half-period divider for note SOL.
- `clk` in 1: 50 MHz system clock (clk50mhz domain).
- `reset_button` in 1: asynchronous, active-low reset.
- `hit_paddle` in 1: level; rising edge requests DO.
- `hit_brick` in 1: level; rising edge requests RE.
- `life_lost` in 1: level; rising edge requests SOL, played at double length.
- `rom_addr` out 5: sine ROM address.
- `tone_en` out 1: high while a note sounds; downstream forces `tono` to 0 when low.
- `note` out 2: code of the current or last note (0 DO, 1 RE, 2 MI, 3 SOL).
- `busy` out 1: FSM not IDLE, or FIFO not empty.
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full.

## Operation
- Inputs are synchronous to `clk`. Synchronisation is done upstream.
- One prev-register per input. An edge is `in & ~prev`.
- Enqueue at most one code per cycle. Priority is life_lost > brick > paddle. Lower-priority edges in the same cycle are discarded and do not set `overflow`.
- FIFO: 4 entries, 3-bit entries: {double_len, code[1:0]}.
- When the FIFO is full and there is no pop that cycle, the edge is dropped and `overflow` is set.
- A push and a pop in the same cycle while full are both accepted.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if the FIFO is not empty, pop and go to PLAY. Load `note`, clear `rom_addr`, step_cnt and dur_cnt.
  - PLAY: step_cnt counts 0..2*DIV(note)-1. On wrap, `rom_addr` increments mod 32. dur_cnt counts to NOTE_LEN-1, or 2*NOTE_LEN-1 when double_len; then go to GAP.
  - GAP: `tone_en`=0 and `rom_addr` is held at 0. Count GAP_LEN cycles, then go to IDLE.
- Counters are 33 bits wide so that 2*NOTE_LEN and 2*DIV cannot overflow.
- MI is reserved: it is never enqueued, but the full decode path for it is present.
- Reset values: `rom_addr`=0, `tone_en`=0, `note`=0, `busy`=0, `overflow`=0. The FIFO is emptied, the prev-registers are cleared and the FSM goes to IDLE.
- Reset asserted mid-note silences the output immediately and discards the queue.

## Timing
- An edge sampled at clk edge k (input high at k, low at k-1) is written into the FIFO at edge k.
- If the FSM is in IDLE, it pops at edge k+1. `tone_en`=1 and `note` are valid from edge k+1. Latency is 1 cycle.
- First `rom_addr` increment occurs 2*DIV cycles after PLAY entry.
- `tone_en` stays high for exactly NOTE_LEN cycles (2*NOTE_LEN when double_len), then stays low for GAP_LEN cycles.
- Minimum spacing between queued notes is NOTE_LEN+GAP_LEN+1 cycles (the extra cycle is the IDLE pop).
- `overflow` rises at the edge of the dropping cycle.
- A level held high produces one event only. A new event needs the input to go low for at least 1 cycle.

## Structure
- Package `sound_pkg`:
  - note code constants `NOTE_DO`/`RE`/`MI`/`SOL`
  - default divider constants
  - FSM state enum `{S_IDLE, S_PLAY, S_GAP}`
  - FIFO entry width
- Sub-module `sound_event_fifo`: 4-deep, 3-bit synchronous FIFO with async active-low reset. Provides `full`/`empty` and supports push and pop in the same cycle.
- The divider mux, counters and FSM live in the top module.

## Test plan
Bench parameters: NOTE_LEN=100, GAP_LEN=20, DIV_DO=4, DIV_RE=5, DIV_SOL=3.
- Single `hit_paddle` pulse at cycle 10:
  - `tone_en` is high over cycles 11–110 and `note`=0.
  - `rom_addr` increments every 8 cycles, reaching 12 at the end of the note.
  - `tone_en` is low for 20 cycles, then `busy`=0.
- `life_lost` pulse: SOL plays for 200 cycles, `rom_addr` steps every 6 cycles and `note`=3.
- `hit_brick` and `hit_paddle` rising in the same cycle: only RE plays and `overflow` stays 0.
- Six paddle edges, 2 cycles apart, while idle: the first is popped at once and the next 4 fill the FIFO. The 6th is dropped and sets `overflow`=1. Exactly 5 notes play.
- `reset_button` low during the 50th cycle of PLAY: `tone_en` and `rom_addr` go to 0 asynchronously, the queue is cleared and no note plays after release.
- `hit_paddle` held high for 500 cycles: exactly one note plays.
